// File: rtl/button_event_decoder.sv
// Turns a debounced button level into short/long/repeat event pulses.
// Ports: CLOCK, Reset (async, low), DebouncedIn, Enable, CountClear in;
//        ShortPress, LongPress, RepeatPulse, Held, PressCount[COUNT_W] out.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int TIMER_W       = 25,
  parameter int COUNT_W       = 8
) (
  input  logic               CLOCK,
  input  logic               Reset,
  input  logic               DebouncedIn,
  input  logic               Enable,
  input  logic               CountClear,
  output logic               ShortPress,
  output logic               LongPress,
  output logic               RepeatPulse,
  output logic               Held,
  output logic [COUNT_W-1:0] PressCount
);

  localparam logic [1:0] S_WAIT_LOW = 2'd0;
  localparam logic [1:0] S_IDLE     = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_REPEAT   = 2'd3;

  localparam logic [TIMER_W-1:0] LONG_LAST =
    TIMER_W'(LONG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REP_LAST =
    TIMER_W'(REPEAT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               short_q, short_d;
  logic               long_q, long_d;
  logic               rep_q, rep_d;
  logic               held_q, held_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    if (!Enable) begin
      state_d = S_WAIT_LOW;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_WAIT_LOW: begin
          // Disarmed until the button is seen released.
          if (!DebouncedIn) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (DebouncedIn) begin
            state_d = S_PRESSED;
            timer_d = '0;
          end
        end
        S_PRESSED: begin
          // Release wins over a coincident long-press terminal count.
          if (!DebouncedIn) begin
            state_d = S_IDLE;
            short_d = 1'b1;
          end else if (timer_q == LONG_LAST) begin
            state_d = S_REPEAT;
            long_d  = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!DebouncedIn) begin
            state_d = S_IDLE;
          end else if (timer_q == REP_LAST) begin
            rep_d   = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = S_WAIT_LOW;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    held_d = (state_d == S_PRESSED) || (state_d == S_REPEAT);
  end

  // Clear beats a coincident increment.
  always_comb begin
    count_d = count_q;
    if (short_d || long_d) count_d = count_q + 1'b1;
    if (CountClear) count_d = '0;
  end

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_WAIT_LOW;
      timer_q <= '0;
      count_q <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

  assign ShortPress  = short_q;
  assign LongPress   = long_q;
  assign RepeatPulse = rep_q;
  assign Held        = held_q;
  assign PressCount  = count_q;

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the switch debouncer and consumes its clean, debounced level.
- Converts that level into one-cycle event pulses: short press, long press, and auto-repeat while held. Also keeps a wrapping count of presses.
- Feeds menu/mode logic that needs press events rather than levels.
- A button already held at reset, or while disabled, generates no events until it has been released once.

Parameters:
- LONG_CYCLES, 25000000, number of cycles the button must be held for a long press (must be >= 2).
- REPEAT_CYCLES, 5000000, period of the auto-repeat pulses after a long press (must be >= 1).
- TIMER_W, 25, hold-timer width; must hold max(LONG_CYCLES, REPEAT_CYCLES)-1.
- COUNT_W, 8, PressCount width.

Ports:
- CLOCK  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- DebouncedIn  in  1  debounced button level from the debouncer, 1 = pressed.
- Enable  in  1  synchronous enable; 0 forces the disarmed state.
- CountClear  in  1  synchronous clear of PressCount.
- ShortPress  out  1  one-cycle pulse: released before LONG_CYCLES.
- LongPress  out  1  one-cycle pulse: held LONG_CYCLES cycles.
- RepeatPulse  out  1  one-cycle pulse every REPEAT_CYCLES while held after LongPress.
- Held  out  1  level, 1 while in PRESSED or REPEAT.
- PressCount  out  COUNT_W  count of ShortPress plus LongPress events, wraps.

Behaviour:
- Reset (asynchronous, Reset=0):
  - state=WAIT_LOW, timer=0, PressCount=0.
  - ShortPress, LongPress, RepeatPulse and Held all 0.
- Registered outputs: every output is a register. An event pulse is high for exactly the one cycle after the clock edge on which its transition is taken.
- States:
  - WAIT_LOW: disarmed. DebouncedIn=0 -> IDLE; otherwise stay.
  - IDLE: DebouncedIn=1 -> PRESSED, timer<=0. This is the acceptance edge.
  - PRESSED:
    - DebouncedIn=0 -> IDLE and ShortPress<=1.
    - else if timer==LONG_CYCLES-1 -> REPEAT, LongPress<=1, timer<=0.
    - else timer<=timer+1.
  - REPEAT:
    - DebouncedIn=0 -> IDLE, no pulse.
    - else if timer==REPEAT_CYCLES-1 -> RepeatPulse<=1, timer<=0.
    - else timer<=timer+1.
- Timing:
  - LongPress is taken on the LONG_CYCLES-th edge after the acceptance edge.
  - The first RepeatPulse follows LongPress by REPEAT_CYCLES cycles; later pulses repeat with the same period.
- Simultaneous events:
  - Release on the same edge where timer==LONG_CYCLES-1 counts as a release: ShortPress only, never both pulses.
  - Release on the REPEAT terminal edge: no RepeatPulse.
- Enable:
  - Enable=0 has priority over all transitions: state<=WAIT_LOW, timer<=0, no pulses, Held<=0, PressCount holds.
  - A button still held when Enable returns to 1 is ignored until it is released.
- Held = 1 in PRESSED or REPEAT, registered with the state.
- PressCount:
  - Increments by 1 on each ShortPress or LongPress transition; RepeatPulse does not count.
  - Wraps from 2^COUNT_W-1 to 0.
  - CountClear=1 sets it to 0 and wins over a coincident increment.
- Reset mid-press: all outputs clear immediately and the state returns to WAIT_LOW. A held button therefore produces no event until it is released and pressed again.
- Timer never exceeds max(LONG_CYCLES, REPEAT_CYCLES)-1 and never wraps.

Test Plan:
(All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=4, COUNT_W=4.)
1. Reset with DebouncedIn=1 held 20 cycles, then Enable=1 -> no pulses, Held=0. Release, then press for 3 cycles -> exactly one ShortPress; PressCount=1; Held high 3 cycles.
2. Press held 20 cycles after IDLE:
   - LongPress one cycle, 8 cycles after acceptance.
   - RepeatPulse at +4 and +8 after LongPress.
   - Release -> no further pulses; PressCount=1.
3. Release on the edge where timer==7 -> ShortPress=1, LongPress stays 0, PressCount increments by 1.
4. 17 short presses -> PressCount wraps 15->0->1. CountClear asserted coincident with a ShortPress -> PressCount=0.
5. Enable dropped mid-press at timer=5 -> Held=0 next cycle, no pulses. Enable restored with button still held -> no events until release then a new press.
6. Reset asserted mid-REPEAT, asynchronously between edges -> all outputs 0 immediately, state WAIT_LOW, PressCount=0.
